dmem_responder: RTL and testbench

- Data-memory target that answers the processor's DMEM initiator port: address, write enable, byte/half-word/sign-extend qualifiers, store data in, load data out.
- Byte-addressed, big-endian, word-organised RAM: combinational load path and synchronous store path.
- Power-on clear sequencer zeroes the array after reset.
- Sticky misaligned-store detection.

---
 rtl/dmem_responder_if.sv | 21 ++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// DMEM initiator <-> responder bus: address, access qualifiers, store data in, load data out.
// Fields use big-endian bit numbering (bit 0 is the MSB).
interface dmem_responder_if;
  logic [0:31] addr;
  logic        write_enable;
  logic        byte_sel;     // byte access; takes priority over half_word
  logic        half_word;
  logic        sign_extend;
  logic [0:31] data_in;
  logic [0:31] data_out;

  modport master (
    output addr, write_enable, byte_sel, half_word, sign_extend, data_in,
    input  data_out
  );

  modport slave (
    input  addr, write_enable, byte_sel, half_word, sign_extend, data_in,
    output data_out
  );
endinterface

// File: rtl/dmem_responder.sv
// Big-endian, word-organised data memory with power-on clear sweep and sticky misaligned-store flag.
// Optional store/error counters are compiled in when DMEM_STATS_EN is defined.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                clock,
  input  logic                reset,
  dmem_responder_if.slave     bus,
  output logic                busy,
  output logic                misaligned,
  output logic [0:31]         err_addr
`ifdef DMEM_STATS_EN
  ,
  output logic [0:15]         wr_count,
  output logic [0:15]         err_count
`endif
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_idx, clr_idx_nxt;
  logic                  clr_we;

  logic [0:31]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic [0:31]           cur;
  logic                  aligned;
  logic                  store_ok, store_bad;
  logic [0:3]            wmask;
  logic [0:31]           wdata, wword;
  logic [0:7]            rbyte;
  logic [0:15]           rhalf;
  logic [0:31]           rdata;

  // Upper address bits alias; they intentionally take no part in decode.
  logic unused_addr;
  assign unused_addr = ^bus.addr[0:29-ADDR_WIDTH];

  assign idx  = bus.addr[30-ADDR_WIDTH:29];
  assign lane = bus.addr[30:31];
  assign cur  = mem[idx];
  assign busy = (state == INIT);

  always_comb begin
    aligned = 1'b1;
    if (bus.byte_sel)       aligned = 1'b1;
    else if (bus.half_word) aligned = ~bus.addr[31];
    else                    aligned = (lane == 2'b00);
  end

  assign store_ok  = bus.write_enable & ~busy &  aligned;
  assign store_bad = bus.write_enable & ~busy & ~aligned;

  // Clear sweep FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_we      = 1'b0;
    case (state)
      INIT: begin
        clr_we      = 1'b1;
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == ADDR_WIDTH'(DEPTH-1)) state_nxt = READY;
      end
      READY: ;
      default: state_nxt = INIT;
    endcase
  end

  // Sub-word stores are replicated across lanes and merged by a byte mask.
  always_comb begin
    if (bus.byte_sel) begin
      wdata = {4{bus.data_in[24:31]}};
      wmask = 4'b1000 >> lane;
    end else if (bus.half_word) begin
      wdata = {2{bus.data_in[16:31]}};
      wmask = bus.addr[30] ? 4'b0011 : 4'b1100;
    end else begin
      wdata = bus.data_in;
      wmask = 4'b1111;
    end
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign wword[8*l +: 8] = wmask[l] ? wdata[8*l +: 8] : cur[8*l +: 8];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clr_we)        mem[clr_idx] <= '0;
      else if (store_ok) mem[idx]     <= wword;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      misaligned <= 1'b0;
      err_addr   <= '0;
    end else if (store_bad) begin
      misaligned <= 1'b1;
      if (!misaligned) err_addr <= bus.addr;
    end
  end

  // Load path
  always_comb begin
    case (lane)
      2'd0:    rbyte = cur[0:7];
      2'd1:    rbyte = cur[8:15];
      2'd2:    rbyte = cur[16:23];
      default: rbyte = cur[24:31];
    endcase
    rhalf = bus.addr[30] ? cur[16:31] : cur[0:15];
    if (busy || !aligned)   rdata = '0;
    else if (bus.byte_sel)  rdata = {{24{bus.sign_extend & rbyte[0]}}, rbyte};
    else if (bus.half_word) rdata = {{16{bus.sign_extend & rhalf[0]}}, rhalf};
    else                    rdata = cur;
  end

  assign bus.data_out = rdata;

`ifdef DMEM_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      if (store_ok  && wr_count  != 16'hFFFF) wr_count  <= wr_count  + 1'b1;
      if (store_bad && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder (ADDR_WIDTH=4) against a byte-array reference model.
module tb_dmem_responder;
  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;
  localparam int NBYTE = DEPTH*4;

  logic clock = 1'b0;
  logic reset;
  logic busy, misaligned;
  logic [31:0] err_addr;
`ifdef DMEM_STATS_EN
  logic [15:0] wr_count, err_count;
`endif

  dmem_responder_if dif();

  dmem_responder #(.ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (dif),
    .busy       (busy),
    .misaligned (misaligned),
    .err_addr   (err_addr)
`ifdef DMEM_STATS_EN
    ,
    .wr_count   (wr_count),
    .err_count  (err_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] d;
    logic        b;
    logic        m;
    logic [31:0] ea;
    logic [15:0] wc;
    logic [15:0] ec;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks   = 0;
  int    failures = 0;

  // Reference model: flat big-endian byte array plus status
  logic [7:0]  mb [NBYTE];
  int          sweep_left = DEPTH;
  bit          m_mis = 0;
  logic [31:0] m_ea = '0;
  int          m_wc = 0, m_ec = 0;

  function automatic bit is_aligned(logic [31:0] a, bit by, bit hw);
    if (by) return 1'b1;
    if (hw) return a[0] == 1'b0;
    return a[1:0] == 2'b00;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, bit by, bit hw, bit se);
    int ba = int'(a) & (NBYTE-1);
    logic [7:0]  v8;
    logic [15:0] v16;
    if (sweep_left > 0 || !is_aligned(a, by, hw)) return 32'h0;
    if (by) begin
      v8 = mb[ba];
      return se ? {{24{v8[7]}}, v8} : {24'h0, v8};
    end
    if (hw) begin
      v16 = {mb[ba], mb[ba+1]};
      return se ? {{16{v16[15]}}, v16} : {16'h0, v16};
    end
    return {mb[ba], mb[ba+1], mb[ba+2], mb[ba+3]};
  endfunction

  task automatic model_edge(bit rst, bit we, bit by, bit hw, logic [31:0] a, logic [31:0] d);
    int ba = int'(a) & (NBYTE-1);
    if (rst) begin
      sweep_left = DEPTH; m_mis = 0; m_ea = '0; m_wc = 0; m_ec = 0;
    end else if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left == 0) for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
    end else if (we) begin
      if (is_aligned(a, by, hw)) begin
        if (by) mb[ba] = d[7:0];
        else if (hw) begin mb[ba] = d[15:8]; mb[ba+1] = d[7:0]; end
        else begin
          mb[ba] = d[31:24]; mb[ba+1] = d[23:16]; mb[ba+2] = d[15:8]; mb[ba+3] = d[7:0];
        end
        if (m_wc < 16'hFFFF) m_wc++;
      end else begin
        if (!m_mis) m_ea = a;
        m_mis = 1;
        if (m_ec < 16'hFFFF) m_ec++;
      end
    end
  endtask

  task automatic cycle(bit rst, bit we, bit by, bit hw, bit se,
                       logic [31:0] a, logic [31:0] d, string nm, bit chk);
    exp_t e;
    reset            = rst;
    dif.addr         = a;
    dif.write_enable = we;
    dif.byte_sel     = by;
    dif.half_word    = hw;
    dif.sign_extend  = se;
    dif.data_in      = d;
    if (chk) begin
      e.d  = model_load(a, by, hw, se);
      e.b  = sweep_left > 0;
      e.m  = m_mis;
      e.ea = m_ea;
      e.wc = 16'(m_wc);
      e.ec = 16'(m_ec);
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
    @(posedge clock);
    #1;
    model_edge(rst, we, by, hw, a, d);
  endtask

  task automatic ld(logic [31:0] a, bit by, bit hw, bit se, string nm);
    cycle(0, 0, by, hw, se, a, 32'h0, nm, 1);
  endtask

  task automatic st(logic [31:0] a, logic [31:0] d, bit by, bit hw, string nm);
    cycle(0, 1, by, hw, 0, a, d, nm, 1);
  endtask

  task automatic rnd_cycles(int n, string nm);
    logic [31:0] a;
    int mode;
    for (int i = 0; i < n; i++) begin
      a    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 127)) : $urandom;
      mode = $urandom_range(0, 2);
      cycle(0, ($urandom_range(0, 2) == 0), mode == 0, mode == 1, $urandom_range(0, 1) == 1,
            a, $urandom, nm, 1);
    end
  endtask

  function automatic void cmp(string nm, string what, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", nm, what, act, want);
    end
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clock) begin
    exp_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      cmp(n, "data_out",   dif.data_out,        e.d);
      cmp(n, "busy",       {31'h0, busy},       {31'h0, e.b});
      cmp(n, "misaligned", {31'h0, misaligned}, {31'h0, e.m});
      cmp(n, "err_addr",   err_addr,            e.ea);
`ifdef DMEM_STATS_EN
      cmp(n, "wr_count",   {16'h0, wr_count},   {16'h0, e.wc});
      cmp(n, "err_count",  {16'h0, err_count},  {16'h0, e.ec});
`endif
    end
  end

  initial begin
    for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, "rst", 0);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, "rst", 1);
    cycle(1, 1, 0, 0, 0, 32'h4, 32'hFFFF_FFFF, "rst", 1);

    st(32'h04, 32'hFFFF_FFFF, 0, 0, "busy_store");
    for (int i = 1; i < DEPTH; i++) ld(32'(i*4), 0, 0, 0, "sweep");
    for (int i = 0; i < DEPTH; i++) ld(32'(i*4), 0, 0, 0, "cleared");

    st(32'h08, 32'h1234_5678, 0, 0, "word_st");
    ld(32'h08, 0, 0, 0, "word_ld");
    ld(32'h09, 1, 0, 0, "byte_ld");
    ld(32'h0A, 0, 1, 0, "half_ld");

    st(32'h0A, 32'h0000_0080, 1, 0, "byte_st");
    ld(32'h0A, 1, 0, 1, "byte_sx");
    ld(32'h0A, 1, 0, 0, "byte_zx");
    ld(32'h08, 0, 0, 0, "byte_merge");

    st(32'h0E, 32'h0000_BEEF, 0, 1, "half_st");
    ld(32'h0E, 0, 1, 1, "half_sx");
    ld(32'h0C, 0, 0, 0, "half_merge");

    st(32'h48, 32'hCAFE_F00D, 0, 0, "wrap_st");
    ld(32'h08, 0, 0, 0, "wrap_ld");

    st(32'h22, 32'hAAAA_5555, 0, 0, "mis_st1");
    st(32'h23, 32'h5555_AAAA, 0, 0, "mis_st2");
    ld(32'h20, 0, 0, 0, "mis_mem");
    ld(32'h22, 0, 0, 0, "mis_ld");
    ld(32'h21, 0, 1, 1, "mis_ld_half");

    rnd_cycles(400, "rand_a");

    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, "rst2", 1);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, "rst2", 1);
    for (int i = 0; i < 7; i++) ld(32'(i*4), 0, 0, 0, "sweep2");
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, "rst_mid", 1);
    for (int i = 0; i < DEPTH + 4; i++) ld(32'(i*4), 0, 0, 0, "resweep");

    rnd_cycles(200, "rand_b");

    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
